// File: rtl/reram_prog_verify_ctrl.sv
// Program-and-verify sequencer for the ReRAM macro command port: turns single-bit
// read/write requests into read, SET and RESET commands with optional verify and retry.
module reram_prog_verify_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int MAX_RETRY   = 3,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_bit,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        done_status,
  output logic              done_rdata,
  output logic [3:0]        done_tries,
  output logic              mac_cmd_valid,
  input  logic              mac_cmd_ready,
  output logic [1:0]        mac_cmd_op,
  output logic [ADDR_W-1:0] mac_cmd_addr,
  input  logic              mac_rsp_valid,
  input  logic              mac_rsp_data
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, PULSE_CMD, PULSE_WAIT, SETTLE, DONE
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_FAIL = 2'b01;
  localparam logic [1:0] ST_TO   = 2'b10;

  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRY);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_next;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bit_q;
  logic [3:0]        tries;
  logic [7:0]        settle_cnt;
  logic [7:0]        to_cnt;
  logic              rdata_q, rdata_new;
  logic [1:0]        status_next;
  logic              load_done;
  logic              verify;
  logic              to_expired;
  logic              accept;
  logic              cmd_entry;

  // Only op 01 verifies; reserved op 11 behaves as a plain read.
  assign verify     = (op_q == 2'b01);
  assign to_expired = (to_cnt >= TO_LAST);
  assign accept     = (state == IDLE) && req_valid;
  assign cmd_entry  = (state_next != state) &&
                      ((state_next == RD_CMD) || (state_next == PULSE_CMD));

  always_comb begin
    state_next  = state;
    status_next = ST_OK;
    load_done   = 1'b0;
    rdata_new   = rdata_q;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (req_op == 2'b10) ? PULSE_CMD : RD_CMD;
      end
      RD_CMD: begin
        if (mac_cmd_ready) begin
          state_next = RD_WAIT;
        end else if (to_expired) begin
          state_next  = DONE;
          status_next = ST_TO;
          load_done   = 1'b1;
        end
      end
      RD_WAIT: begin
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (mac_rsp_valid) begin
          rdata_new = mac_rsp_data;
          if (!verify || (mac_rsp_data == bit_q)) begin
            state_next = DONE;
            load_done  = 1'b1;
          end else if (tries >= RETRY_MAX) begin
            state_next  = DONE;
            status_next = ST_FAIL;
            load_done   = 1'b1;
          end else begin
            state_next = PULSE_CMD;
          end
        end else if (to_expired) begin
          state_next  = DONE;
          status_next = ST_TO;
          load_done   = 1'b1;
        end
      end
      PULSE_CMD: begin
        if (mac_cmd_ready) begin
          state_next = PULSE_WAIT;
        end else if (to_expired) begin
          state_next  = DONE;
          status_next = ST_TO;
          load_done   = 1'b1;
        end
      end
      PULSE_WAIT: begin
        if (mac_rsp_valid) begin
          if (verify) begin
            state_next = SETTLE;
          end else begin
            state_next = DONE;
            load_done  = 1'b1;
          end
        end else if (to_expired) begin
          state_next  = DONE;
          status_next = ST_TO;
          load_done   = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt >= SETTLE_LAST) state_next = RD_CMD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= '0;
      bit_q       <= 1'b0;
      tries       <= 4'd0;
      settle_cnt  <= 8'd0;
      to_cnt      <= 8'd0;
      rdata_q     <= 1'b0;
      done_status <= ST_OK;
      done_rdata  <= 1'b0;
      done_tries  <= 4'd0;
    end else begin
      state   <= state_next;
      rdata_q <= rdata_new;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        bit_q  <= req_bit;
        tries  <= 4'd0;
      end else if ((state == PULSE_CMD) && mac_cmd_ready && (tries != 4'd15)) begin
        tries <= tries + 4'd1;
      end
      settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      // One budget covers a command phase together with its response wait.
      if (cmd_entry) begin
        to_cnt <= 8'd0;
      end else if (((state == RD_CMD) || (state == RD_WAIT) ||
                    (state == PULSE_CMD) || (state == PULSE_WAIT)) && (to_cnt != 8'hFF)) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (load_done) begin
        done_status <= status_next;
        done_rdata  <= rdata_new;
        done_tries  <= tries;
      end
    end
  end

  assign req_ready     = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign mac_cmd_valid = (state == RD_CMD) || (state == PULSE_CMD);
  assign mac_cmd_op    = (state == PULSE_CMD) ? (bit_q ? OP_SET : OP_RST) : OP_RD;
  assign mac_cmd_addr  = addr_q;

endmodule

// File: tb/tb_reram_prog_verify_ctrl.sv
// Scoreboard bench: a behavioural macro answers commands, expected commands and
// completions are queued by the stimulus and popped by independent monitors.
module tb_reram_prog_verify_ctrl;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_bit;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              busy_o, done_o, done_rdata;
  logic [1:0]        done_status;
  logic [3:0]        done_tries;
  logic              mac_cmd_valid, mac_cmd_ready, mac_rsp_valid, mac_rsp_data;
  logic [1:0]        mac_cmd_op;
  logic [ADDR_W-1:0] mac_cmd_addr;

  always #5 clk = ~clk;

  reram_prog_verify_ctrl #(.ADDR_W(ADDR_W), .MAX_RETRY(3), .SETTLE_CYC(4), .TIMEOUT_CYC(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_bit(req_bit), .busy_o(busy_o),
    .done_o(done_o), .done_status(done_status), .done_rdata(done_rdata),
    .done_tries(done_tries), .mac_cmd_valid(mac_cmd_valid), .mac_cmd_ready(mac_cmd_ready),
    .mac_cmd_op(mac_cmd_op), .mac_cmd_addr(mac_cmd_addr), .mac_rsp_valid(mac_rsp_valid),
    .mac_rsp_data(mac_rsp_data)
  );

  typedef struct { logic [1:0] st; logic rd; logic rd_chk; logic [3:0] tr; } done_t;
  typedef struct { logic [1:0] op; logic [ADDR_W-1:0] addr; } cmd_t;

  done_t exp_done_q[$];
  cmd_t  exp_cmd_q[$];
  bit    rd_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, n_done = 0, done_cyc = 0, last_rsp_cyc = 0, min_gap = 1000, rsp_lat = 0;
  logic rdy_after = 1'b0, chk_rdy = 1'b0, last_was_pulse = 1'b0;
  done_t d_e;
  cmd_t  c_e;
  logic [1:0] m_op;
  logic [ADDR_W-1:0] m_addr;
  logic m_data;
  int gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completion monitor
  initial forever begin
    @(negedge clk);
    if (chk_rdy) begin
      rdy_after = req_ready;
      chk_rdy   = 1'b0;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
      chk_rdy  = 1'b1;
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got status %0d expected no completion", done_status);
      end else begin
        d_e = exp_done_q.pop_front();
        check("done_status", 32'(done_status), 32'(d_e.st));
        if (d_e.rd_chk) check("done_rdata", 32'(done_rdata), 32'(d_e.rd));
        check("done_tries", 32'(done_tries), 32'(d_e.tr));
      end
    end
  end

  // Macro model and command monitor
  initial begin
    mac_rsp_valid = 1'b0;
    mac_rsp_data  = 1'b0;
    forever begin
      @(negedge clk);
      if (mac_cmd_valid && mac_cmd_ready && !rst) begin
        m_op   = mac_cmd_op;
        m_addr = mac_cmd_addr;
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got op %0d expected no command", m_op);
        end else begin
          c_e = exp_cmd_q.pop_front();
          check("cmd_op", 32'(m_op), 32'(c_e.op));
          check("cmd_addr", 32'(m_addr), 32'(c_e.addr));
        end
        if (m_op == 2'b00 && last_was_pulse) begin
          gap = cyc - last_rsp_cyc;
          if (gap < min_gap) min_gap = gap;
        end
        last_was_pulse = (m_op != 2'b00);
        m_data = (m_op == 2'b00 && rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
        @(posedge clk);
        repeat (rsp_lat) @(posedge clk);
        #1 mac_rsp_valid = 1'b1;
        mac_rsp_data = m_data;
        @(posedge clk);
        #1 last_rsp_cyc = cyc;
        mac_rsp_valid = 1'b0;
        mac_rsp_data  = 1'b0;
      end
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic b);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_bit   = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (n_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got %0d completions expected %0d", n_done, target);
    end
    repeat (3) @(negedge clk);
    check("done_pulse_count", 32'(n_done), 32'(target));
  endtask

  function automatic done_t mk_done(input logic [1:0] st, input logic rd, input logic rd_chk,
                                    input logic [3:0] tr);
    done_t d;
    d.st = st; d.rd = rd; d.rd_chk = rd_chk; d.tr = tr;
    return d;
  endfunction

  function automatic cmd_t mk_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    cmd_t c;
    c.op = op; c.addr = addr;
    return c;
  endfunction

  initial begin
    int cnt, n;
    logic [1:0] first_op;
    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_bit = 1'b0;
    mac_cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done_o", 32'(done_o), 32'd0);
    check("rst_done_status", 32'(done_status), 32'd0);
    check("rst_done_rdata", 32'(done_rdata), 32'd0);
    check("rst_done_tries", 32'(done_tries), 32'd0);
    check("rst_cmd_valid", 32'(mac_cmd_valid), 32'd0);
    check("rst_cmd_op", 32'(mac_cmd_op), 32'd0);
    check("rst_cmd_addr", 32'(mac_cmd_addr), 32'd0);
    rst = 1'b0;

    // Plain read, response three cycles after the command
    rsp_lat = 2;
    rd_q.push_back(1'b1);
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h155));
    exp_done_q.push_back(mk_done(2'b00, 1'b1, 1'b1, 4'd0));
    send_req(2'b00, 10'h155, 1'b0);
    wait_done(1);
    check("rsp_to_done_latency", 32'(done_cyc), 32'(last_rsp_cyc));
    check("ready_after_done", 32'(rdy_after), 32'd1);

    // Verified write whose pre-read already matches
    rsp_lat = 0;
    rd_q.push_back(1'b1);
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h02A));
    exp_done_q.push_back(mk_done(2'b00, 1'b1, 1'b1, 4'd0));
    send_req(2'b01, 10'h02A, 1'b1);
    wait_done(2);

    // Verified RESET that succeeds on the second pulse
    min_gap = 1000;
    rd_q.push_back(1'b1); rd_q.push_back(1'b1); rd_q.push_back(1'b0);
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h3C0));
    exp_cmd_q.push_back(mk_cmd(2'b10, 10'h3C0));
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h3C0));
    exp_cmd_q.push_back(mk_cmd(2'b10, 10'h3C0));
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h3C0));
    exp_done_q.push_back(mk_done(2'b00, 1'b0, 1'b1, 4'd2));
    send_req(2'b01, 10'h3C0, 1'b0);
    wait_done(3);

    // Verified SET that never takes: retries exhausted
    for (int i = 0; i < 4; i++) rd_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_cmd_q.push_back(mk_cmd(2'b00, 10'h001));
      exp_cmd_q.push_back(mk_cmd(2'b01, 10'h001));
    end
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h001));
    exp_done_q.push_back(mk_done(2'b01, 1'b0, 1'b1, 4'd3));
    send_req(2'b01, 10'h001, 1'b1);
    wait_done(4);
    check("settle_gap_min", 32'(min_gap >= 4), 32'd1);

    // Unverified RESET
    rsp_lat = 1;
    exp_cmd_q.push_back(mk_cmd(2'b10, 10'h0F0));
    exp_done_q.push_back(mk_done(2'b00, 1'b0, 1'b0, 4'd1));
    send_req(2'b10, 10'h0F0, 1'b0);
    wait_done(5);

    // Unverified SET with the macro never accepting
    mac_cmd_ready = 1'b0;
    exp_done_q.push_back(mk_done(2'b10, 1'b0, 1'b0, 4'd0));
    send_req(2'b10, 10'h0AA, 1'b1);
    cnt = 0; n = 0; first_op = 2'b11;
    @(negedge clk);
    while (mac_cmd_valid && n < 400) begin
      if (cnt == 0) first_op = mac_cmd_op;
      cnt++;
      n++;
      @(negedge clk);
    end
    check("timeout_valid_cycles", 32'(cnt), 32'd255);
    check("timeout_pulse_op", 32'(first_op), 32'd1);
    check("timeout_done_o", 32'(done_o), 32'd1);
    check("timeout_ready_in_done", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("timeout_ready_after", 32'(req_ready), 32'd1);
    mac_cmd_ready = 1'b1;
    wait_done(6);

    // Reset during PULSE_WAIT with a late macro response
    rsp_lat = 20;
    exp_cmd_q.push_back(mk_cmd(2'b10, 10'h1F0));
    send_req(2'b10, 10'h1F0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(mac_cmd_valid && mac_cmd_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_cmd_valid", 32'(mac_cmd_valid), 32'd0);
    check("post_reset_done_o", 32'(done_o), 32'd0);
    repeat (30) @(negedge clk);
    check("late_rsp_ignored_busy", 32'(busy_o), 32'd0);
    check("late_rsp_no_done", 32'(n_done), 32'd6);

    // Reserved op behaves as a read
    rsp_lat = 1;
    rd_q.push_back(1'b0);
    exp_cmd_q.push_back(mk_cmd(2'b00, 10'h3FF));
    exp_done_q.push_back(mk_done(2'b00, 1'b0, 1'b1, 4'd0));
    send_req(2'b11, 10'h3FF, 1'b1);
    wait_done(7);

    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reram_prog_verify_ctrl.md
# reram_prog_verify_ctrl

Program-and-verify sequencer between the Wishbone-side request logic and the Neuromorphic X1 ReRAM macro command port. It accepts single-bit read/write requests and converts writes into SET or RESET pulses. For verified writes it pre-reads, pulses, waits a settle time, read-verifies, and retries up to a bounded count. It reports pass, verify-fail or timeout per request. It sits inside the user project, in the Caravel user area, between the Wishbone slave decode and the analog macro.

## Interface
Parameters:
- ADDR_W, 10, cell address width (row/column concatenated, 32x32 array).
- MAX_RETRY, 3, maximum pulses per verified write (1..15).
- SETTLE_CYC, 4, idle cycles between pulse response and verify read (1..255).
- TIMEOUT_CYC, 255, maximum cycles allowed per macro command/response phase (1..255).

Ports:
- wb_clk_i  in  1  single clock; everything is synchronous to it.
- wb_rst_i  in  1  synchronous active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 read, 01 write with verify, 10 write without verify, 11 reserved (treated as read).
- req_addr  in  ADDR_W  target cell.
- req_bit  in  1  target value for writes: 1 means SET, 0 means RESET.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- done_status  out  2  00 ok, 01 verify fail, 10 timeout.
- done_rdata  out  1  last value read from the cell.
- done_tries  out  4  number of pulses issued for this request.
- mac_cmd_valid  out  1  command strobe to the macro.
- mac_cmd_ready  in  1  macro accepts the command.
- mac_cmd_op  out  2  00 read, 01 set, 10 reset.
- mac_cmd_addr  out  ADDR_W  cell address.
- mac_rsp_valid  in  1  macro completion (pulse done or read data valid).
- mac_rsp_data  in  1  read data; only meaningful for read commands.

## Operation
- States: IDLE, RD_CMD, RD_WAIT, PULSE_CMD, PULSE_WAIT, SETTLE, DONE.
- IDLE: req_ready=1. On req_valid, the block latches op, addr and bit, clears tries, and moves to:
  - RD_CMD for a read or a verified write;
  - PULSE_CMD for an unverified write.
- RD_CMD / PULSE_CMD: mac_cmd_valid=1 with op and addr held stable until mac_cmd_ready. Then move to RD_WAIT or PULSE_WAIT.
- PULSE_CMD sets tries+1 on the handshake.
- RD_WAIT: on mac_rsp_valid, latch rdata.
  - Read: go to DONE with status ok.
  - Verified write, rdata==bit: go to DONE with status ok. When this happens on the pre-read, tries=0 and no pulse is issued.
  - Verified write, mismatch, tries<MAX_RETRY: go to PULSE_CMD.
  - Verified write, mismatch, tries==MAX_RETRY: go to DONE with status fail.
- PULSE_WAIT: on mac_rsp_valid, go to SETTLE for a verified write, or to DONE with status ok for an unverified write.
- SETTLE: counts SETTLE_CYC cycles, then goes to RD_CMD.
- Timeout: a counter clears on entry to each *_CMD state and counts each cycle spent in *_CMD or *_WAIT. When it reaches TIMEOUT_CYC the block goes to DONE with status timeout. mac_cmd_valid drops that same cycle.
- DONE: done_o=1 for one cycle and done_status/done_rdata/done_tries update; then IDLE.
- done_status, done_rdata and done_tries hold their values until the next DONE.
- mac_rsp_valid is ignored outside the *_WAIT states.
- mac_cmd_op for a pulse is 01 when bit=1 and 10 when bit=0.

## Timing
- Reset values: state IDLE, req_ready=1, busy_o=0, done_o=0, done_status=00, done_rdata=0, done_tries=0, mac_cmd_valid=0, mac_cmd_op=00, mac_cmd_addr=0. All counters are 0.
- Reset asserted mid-operation: the next cycle is IDLE with mac_cmd_valid=0 and no done_o. Any macro response that was in flight is ignored.
- Request accepted at edge N: mac_cmd_valid is high from cycle N+1.
- mac_rsp_valid seen at edge M on the final phase: done_o is high in cycle M+1, and req_ready is high in cycle M+2.
- The minimum verified-write latency with a matching pre-read, single-cycle cmd_ready and rsp_valid in the first WAIT cycle is 4 cycles from acceptance to done_o.
- The tries counter saturates at 15.
- The SETTLE counter is 8 bits wide.
- Simultaneous timeout expiry and mac_rsp_valid: the response wins.

## Test plan
- Read, addr=0x155, macro returns 1 after 3 cycles -> done_o pulses once; status=00, rdata=1, tries=0; exactly one mac_cmd with op=00.
- Verified write bit=1, pre-read returns 1 -> status=00, tries=0; no set/reset command issued.
- Verified write bit=0, pre-read 1, first verify 1, second verify 0 -> commands in order: read, reset, read, reset, read. SETTLE gap ≥4 cycles before each verify; status=00, tries=2.
- Verified write bit=1, every read returns 0, MAX_RETRY=3 -> 3 set pulses, 4 reads; status=01, tries=3, rdata=0.
- Unverified write bit=1, mac_cmd_ready held low -> after 255 cycles status=10, mac_cmd_valid drops, req_ready returns 2 cycles later.
- wb_rst_i pulsed during PULSE_WAIT -> next cycle busy_o=0 and mac_cmd_valid=0; no done_o; a late mac_rsp_valid is ignored and the next request completes normally.
